regfile_mp: RTL and testbench

- Parametrised multi-read-port register file; next generation of the single-write, two-read register file in the MIPS datapath.
- Generalised in data width, depth and read-port count.
- Adds a hardware clear sequencer that sweeps every entry to zero after reset or on request, with a busy flag.
- Optional hardwired-zero entry 0 and optional write-to-read bypass for pipelined use.

---
 rtl/regfile_mp.sv | 96 +++++++++
 tb/tb_regfile_mp.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a clear sweeper; optional write-to-read bypass under REGFILE_BYPASS_EN.
// Latency: reads are combinational (zero cycles), writes land on the rising edge, and a clear sweep takes DEPTH edges.
// Backpressure: none. While busy is high, writes and clear requests are dropped and every read port returns 0.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  output logic                       busy,
  input  logic                       write,
  input  logic [ADDR_W-1:0]          wrAddr,
  input  logic [DATA_W-1:0]          wrData,
  input  logic [NUM_RD*ADDR_W-1:0]   rdAddr,
  output logic [NUM_RD*DATA_W-1:0]   rdData
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_t;

  state_t              state;
  state_t              stateNext;
  logic [ADDR_W-1:0]   clrPtr;
  logic                userWr;
  logic                memWe;
  logic [ADDR_W-1:0]   memAddr;
  logic [DATA_W-1:0]   memData;
  logic [DATA_W-1:0]   mem [DEPTH];

  // A clear request wins over a simultaneous write, and entry 0 is read-only when it is hardwired to zero.
  assign userWr = write && !clear && !((ZERO_REG != 0) && (wrAddr == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= CLEAR;
      clrPtr <= '0;
    end else begin
      state <= stateNext;
      if (state == CLEAR && clrPtr != LAST_PTR)
        clrPtr <= clrPtr + ADDR_W'(1);
      else
        clrPtr <= '0;
    end
  end

  always_comb begin
    stateNext = state;
    if (state == CLEAR) begin
      if (clrPtr == LAST_PTR)
        stateNext = READY;
    end else begin
      if (clear)
        stateNext = CLEAR;
    end
  end

  always_comb begin
    busy    = (state == CLEAR);
    memWe   = 1'b0;
    memAddr = wrAddr;
    memData = wrData;
    if (state == CLEAR) begin
      memWe   = 1'b1;
      memAddr = clrPtr;
      memData = '0;
    end else begin
      memWe   = userWr;
    end
  end

  // The storage array has no reset; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (memWe)
      mem[memAddr] <= memData;
  end

  always_comb begin
    rdData = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (!reset && state == READY &&
          !((ZERO_REG != 0) && (rdAddr[k*ADDR_W +: ADDR_W] == '0))) begin
        rdData[k*DATA_W +: DATA_W] = mem[rdAddr[k*ADDR_W +: ADDR_W]];
`ifdef REGFILE_BYPASS_EN
        if (write && !clear && (wrAddr == rdAddr[k*ADDR_W +: ADDR_W]))
          rdData[k*DATA_W +: DATA_W] = wrData;
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: stimulus queues expected busy/read values and a negedge monitor compares them.
module tb_regfile_mp;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        busy;
  logic        write;
  logic [4:0]  wrAddr;
  logic [31:0] wrData;
  logic [9:0]  rdAddr;
  logic [63:0] rdData;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic        chkRd;
    logic        expB;
    logic [31:0] e0;
    logic [31:0] e1;
  } exp_t;

  exp_t  expQ[$];
  string nameQ[$];
  exp_t  cur;
  string curName;
  int    checks = 0;
  int    errors = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1)) dut (
    .clk(clk), .reset(reset), .clear(clear), .busy(busy), .write(write),
    .wrAddr(wrAddr), .wrData(wrData), .rdAddr(rdAddr), .rdData(rdData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: everything queued since the last falling edge is compared here.
  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      cur     = expQ.pop_front();
      curName = nameQ.pop_front();
      checks++;
      if (busy !== cur.expB) begin
        errors++;
        $display("FAIL %s busy got %0b want %0b", curName, busy, cur.expB);
      end
      if (cur.chkRd) begin
        checks++;
        if (rdData[31:0] !== cur.e0) begin
          errors++;
          $display("FAIL %s rd0 got %h want %h", curName, rdData[31:0], cur.e0);
        end
        checks++;
        if (rdData[63:32] !== cur.e1) begin
          errors++;
          $display("FAIL %s rd1 got %h want %h", curName, rdData[63:32], cur.e1);
        end
      end
    end
  end

  task automatic expectOut(input string n, input logic eb, input logic chkRd,
                           input logic [31:0] e0, input logic [31:0] e1);
    exp_t e;
    e.chkRd = chkRd;
    e.expB  = eb;
    e.e0    = e0;
    e.e1    = e1;
    expQ.push_back(e);
    nameQ.push_back(n);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setRd(input int a0, input int a1);
    rdAddr = {5'(a1), 5'(a0)};
  endtask

  // Caller is just past the edge that left the FSM in CLEAR with clrPtr=0.
  task automatic sweep(input string n);
    for (int i = 1; i <= 32; i++) begin
      step();
      write = 1'b0;
      clear = 1'b0;
      expectOut(n, (i < 32), (i < 32), 32'h0, 32'h0);
    end
  endtask

  task automatic readAll(input string n, input logic [31:0] val);
    for (int i = 0; i < 16; i++) begin
      step();
      setRd(2*i, 2*i + 1);
      expectOut(n, 1'b0, 1'b1, (i == 0) ? 32'h0 : val, val);
    end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; write = 1'b0;
    wrAddr = '0; wrData = '0; rdAddr = '0;
    #2;
    expectOut("rstInit", 1'b1, 1'b1, 32'h0, 32'h0);
    step();
    reset = 1'b0;
    sweep("initSweep");

    // Fill every entry with all-ones without any sweep in between.
    for (int i = 0; i < 32; i++) begin
      step();
      write = 1'b1; wrAddr = 5'(i); wrData = 32'hFFFF_FFFF;
    end
    step();
    write = 1'b0;
    readAll("prefill", 32'hFFFF_FFFF);

    // An asynchronous reset forces busy and zero reads before any clock edge.
    step();
    setRd(1, 31);
    reset = 1'b1;
    #1;
    expectOut("rstAsync", 1'b1, 1'b1, 32'h0, 32'h0);
    step();
    reset = 1'b0;
    sweep("rstSweep");
    readAll("afterSweep", 32'h0);

    step();
    write = 1'b1; wrAddr = 5'd5; wrData = 32'hDEAD_BEEF; setRd(10, 11);
    expectOut("wr5", 1'b0, 1'b1, 32'h0, 32'h0);
    step();
    write = 1'b0; setRd(5, 5);
    expectOut("rd5", 1'b0, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    step();
    write = 1'b1; wrAddr = 5'd0; wrData = 32'h1234; setRd(0, 5);
    expectOut("wr0", 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF);
    step();
    write = 1'b0;
    expectOut("rd0", 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF);

    step();
    write = 1'b1; wrAddr = 5'd31; wrData = 32'hA5A5_A5A5; setRd(31, 31);
    expectOut("wr31", 1'b0, 1'b1, BYP ? 32'hA5A5_A5A5 : 32'h0, BYP ? 32'hA5A5_A5A5 : 32'h0);
    step();
    write = 1'b0; clear = 1'b1;
    expectOut("clrReq", 1'b0, 1'b1, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
    step();
    clear = 1'b0; write = 1'b1; wrAddr = 5'd7; wrData = 32'h99; setRd(31, 7);
    expectOut("clrBusy", 1'b1, 1'b1, 32'h0, 32'h0);
    sweep("clrSweep");
    expectOut("clrAfter", 1'b0, 1'b1, 32'h0, 32'h0);

    // Reset at sweep cycle 10 must restart the full sweep.
    step();
    write = 1'b1; wrAddr = 5'd12; wrData = 32'hCAFE; setRd(12, 5);
    expectOut("wr12", 1'b0, 1'b1, BYP ? 32'hCAFE : 32'h0, 32'h0);
    step();
    write = 1'b0; clear = 1'b1;
    expectOut("clr2Req", 1'b0, 1'b1, 32'hCAFE, 32'h0);
    step();
    clear = 1'b0;
    expectOut("midSweep", 1'b1, 1'b1, 32'h0, 32'h0);
    for (int i = 1; i <= 10; i++) begin
      step();
      expectOut("midSweep", 1'b1, 1'b1, 32'h0, 32'h0);
    end
    reset = 1'b1;
    #1;
    expectOut("midRst", 1'b1, 1'b1, 32'h0, 32'h0);
    step();
    reset = 1'b0;
    sweep("restartSweep");
    expectOut("restartAfter", 1'b0, 1'b1, 32'h0, 32'h0);

    step();
    write = 1'b1; wrAddr = 5'd3; wrData = 32'h55; setRd(3, 3);
    expectOut("byp3", 1'b0, 1'b1, BYP ? 32'h55 : 32'h0, BYP ? 32'h55 : 32'h0);
    step();
    write = 1'b0;
    expectOut("rd3", 1'b0, 1'b1, 32'h55, 32'h55);

    step();
    clear = 1'b1; write = 1'b1; wrAddr = 5'd9; wrData = 32'h77; setRd(9, 3);
    expectOut("clrWr9", 1'b0, 1'b1, 32'h0, 32'h55);
    step();
    clear = 1'b0; write = 1'b0;
    expectOut("clrWr9Busy", 1'b1, 1'b1, 32'h0, 32'h0);
    sweep("clrWr9Sweep");
    expectOut("rd9", 1'b0, 1'b1, 32'h0, 32'h0);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
